// File: rtl/schedule_scoreboard_pkg.sv
// Shared constants and helpers for the schedule-stage register-hazard scoreboard.
package schedule_scoreboard_pkg;

   localparam int REG_ADDR_W       = 5;
   localparam int NUM_REGS_DEF     = 32;
   localparam int CNT_W_DEF        = 2;
   localparam int MAX_INFLIGHT_DEF = 8;
   localparam int INF_W_DEF        = 4;

   localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

   // x0 is hard-wired zero, so it never carries a hazard
   function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
      return (addr == REG_X0);
   endfunction

endpackage

// File: rtl/schedule_scoreboard_cnt.sv
// Per-register pending-write counter: saturating up/down count, ignores decrement at zero.
module schedule_scoreboard_cnt
   import schedule_scoreboard_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             clr,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             is_one,
   output logic             is_max
);

   logic [CNT_W-1:0] count_r;
   logic             dec_eff_s;
   logic             inc_eff_s;

   // Qualify requests: no decrement below zero, no increment past max unless a retire frees a slot
   always_comb begin
      dec_eff_s = dec & (count_r != {CNT_W{1'b0}});
      inc_eff_s = inc & (~(&count_r) | dec_eff_s);
   end

   // Counter state with async reset and synchronous clear
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clr) begin
         count_r <= {CNT_W{1'b0}};
      end else if (inc_eff_s && !dec_eff_s) begin
         count_r <= count_r + CNT_W'(1);
      end else if (dec_eff_s && !inc_eff_s) begin
         count_r <= count_r - CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign count  = count_r;
   assign is_one = (count_r == CNT_W'(1));
   assign is_max = &count_r;

endmodule

// File: rtl/schedule_scoreboard.sv
// Register-hazard scoreboard: tracks pending destination writes per register and gates
// issue on RAW hazards, counter saturation and total in-flight capacity.
module schedule_scoreboard
   import schedule_scoreboard_pkg::*;
#(
   parameter int NUM_REGS     = NUM_REGS_DEF,
   parameter int CNT_W        = CNT_W_DEF,
   parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
   parameter int INF_W        = INF_W_DEF
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  FLUSH,
   input  logic                  ISSUE_VALID,
   input  logic [REG_ADDR_W-1:0] ISSUE_RD,
   input  logic                  ISSUE_WRITE_RD,
   input  logic [REG_ADDR_W-1:0] ISSUE_RS1,
   input  logic                  ISSUE_USE_RS1,
   input  logic [REG_ADDR_W-1:0] ISSUE_RS2,
   input  logic                  ISSUE_USE_RS2,
   output logic                  ISSUE_READY,
   output logic                  STALL,
   input  logic                  WB_VALID,
   input  logic [REG_ADDR_W-1:0] WB_RD,
   output logic [NUM_REGS-1:0]   BUSY_MASK,
   output logic [INF_W-1:0]      INFLIGHT_COUNT,
   output logic                  ERR_UNDERFLOW
);

   logic                trk_wr_s;
   logic                trk_wb_s;
   logic                accept_wr_s;
   logic                retire_s;
   logic                underflow_s;
   logic                raw1_s;
   logic                raw2_s;
   logic                sat_s;
   logic                cap_s;
   logic                ready_s;
   logic [NUM_REGS-1:0] busy_s;
   logic [NUM_REGS-1:0] one_s;
   logic [NUM_REGS-1:0] max_s;
   logic [NUM_REGS-1:0] inc_s;
   logic [NUM_REGS-1:0] wb_hit_s;
   logic [NUM_REGS-1:0] busy_eff_s;
   logic [INF_W-1:0]    inflight_r;
   logic                err_underflow_r;

   assign trk_wr_s = ISSUE_WRITE_RD & ~is_x0(ISSUE_RD);
   assign trk_wb_s = WB_VALID & ~is_x0(WB_RD);

   assign busy_s[0]   = 1'b0;
   assign one_s[0]    = 1'b0;
   assign max_s[0]    = 1'b0;
   assign inc_s[0]    = 1'b0;
   assign wb_hit_s[0] = 1'b0;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
      logic [CNT_W-1:0] cnt_s;

      assign inc_s[r]    = accept_wr_s & (ISSUE_RD == REG_ADDR_W'(r));
      assign wb_hit_s[r] = trk_wb_s & (WB_RD == REG_ADDR_W'(r));
      assign busy_s[r]   = (cnt_s != {CNT_W{1'b0}});

      schedule_scoreboard_cnt #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .CLK    (CLK),
         .RST    (RST),
         .clr    (FLUSH),
         .inc    (inc_s[r]),
         .dec    (wb_hit_s[r]),
         .count  (cnt_s),
         .is_one (one_s[r]),
         .is_max (max_s[r])
      );
   end

   // Hazard evaluation; a last pending write retiring this cycle is forwarded, so it is not busy
   always_comb begin
      busy_eff_s  = busy_s & ~(one_s & wb_hit_s);
      raw1_s      = ISSUE_USE_RS1 & busy_eff_s[ISSUE_RS1];
      raw2_s      = ISSUE_USE_RS2 & busy_eff_s[ISSUE_RS2];
      sat_s       = trk_wr_s & max_s[ISSUE_RD] & ~wb_hit_s[ISSUE_RD];
      cap_s       = trk_wr_s & (inflight_r >= INF_W'(MAX_INFLIGHT)) & ~trk_wb_s;
      ready_s     = ~RST & ~FLUSH & ~raw1_s & ~raw2_s & ~sat_s & ~cap_s;
      accept_wr_s = ISSUE_VALID & ready_s & trk_wr_s;
      retire_s    = trk_wb_s & busy_s[WB_RD] & ~FLUSH;
      underflow_s = trk_wb_s & ~busy_s[WB_RD] & ~FLUSH;
   end

   // Total outstanding tracked writes, kept equal to the sum of the per-register counters
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         inflight_r <= {INF_W{1'b0}};
      end else if (FLUSH) begin
         inflight_r <= {INF_W{1'b0}};
      end else if (accept_wr_s && !retire_s) begin
         inflight_r <= inflight_r + INF_W'(1);
      end else if (retire_s && !accept_wr_s) begin
         inflight_r <= inflight_r - INF_W'(1);
      end else begin
         inflight_r <= inflight_r;
      end
   end

   // Sticky underflow flag survives FLUSH; only reset clears it
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         err_underflow_r <= 1'b0;
      end else if (underflow_s) begin
         err_underflow_r <= 1'b1;
      end else begin
         err_underflow_r <= err_underflow_r;
      end
   end

   assign ISSUE_READY    = ready_s;
   assign STALL          = ISSUE_VALID & ~ready_s;
   assign BUSY_MASK      = busy_s;
   assign INFLIGHT_COUNT = inflight_r;
   assign ERR_UNDERFLOW  = err_underflow_r;

endmodule

// File: tb/tb_schedule_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic against a per-register count model.
module tb_schedule_scoreboard;

   logic        CLK;
   logic        RST;
   logic        FLUSH;
   logic        ISSUE_VALID;
   logic [4:0]  ISSUE_RD;
   logic        ISSUE_WRITE_RD;
   logic [4:0]  ISSUE_RS1;
   logic        ISSUE_USE_RS1;
   logic [4:0]  ISSUE_RS2;
   logic        ISSUE_USE_RS2;
   logic        ISSUE_READY;
   logic        STALL;
   logic        WB_VALID;
   logic [4:0]  WB_RD;
   logic [31:0] BUSY_MASK;
   logic [3:0]  INFLIGHT_COUNT;
   logic        ERR_UNDERFLOW;

   int checks   = 0;
   int failures = 0;
   int m_cnt[32];
   bit m_err;

   localparam int MAX_CNT = 3;
   localparam int MAX_INF = 8;

   schedule_scoreboard dut (
      .CLK            (CLK),
      .RST            (RST),
      .FLUSH          (FLUSH),
      .ISSUE_VALID    (ISSUE_VALID),
      .ISSUE_RD       (ISSUE_RD),
      .ISSUE_WRITE_RD (ISSUE_WRITE_RD),
      .ISSUE_RS1      (ISSUE_RS1),
      .ISSUE_USE_RS1  (ISSUE_USE_RS1),
      .ISSUE_RS2      (ISSUE_RS2),
      .ISSUE_USE_RS2  (ISSUE_USE_RS2),
      .ISSUE_READY    (ISSUE_READY),
      .STALL          (STALL),
      .WB_VALID       (WB_VALID),
      .WB_RD          (WB_RD),
      .BUSY_MASK      (BUSY_MASK),
      .INFLIGHT_COUNT (INFLIGHT_COUNT),
      .ERR_UNDERFLOW  (ERR_UNDERFLOW)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_sum();
      int s = 0;
      for (int i = 0; i < 32; i++) s += m_cnt[i];
      return s;
   endfunction

   function automatic bit model_busy(input int r);
      if (r == 0) return 1'b0;
      if (m_cnt[r] == 0) return 1'b0;
      if (m_cnt[r] == 1 && WB_VALID && int'(WB_RD) == r) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit model_ready();
      bit tw = ISSUE_WRITE_RD && ISSUE_RD != 5'd0;
      bit tb = WB_VALID && WB_RD != 5'd0;
      if (FLUSH) return 1'b0;
      if (ISSUE_USE_RS1 && model_busy(int'(ISSUE_RS1))) return 1'b0;
      if (ISSUE_USE_RS2 && model_busy(int'(ISSUE_RS2))) return 1'b0;
      if (tw && m_cnt[ISSUE_RD] == MAX_CNT && !(tb && WB_RD == ISSUE_RD)) return 1'b0;
      if (tw && model_sum() >= MAX_INF && !tb) return 1'b0;
      return 1'b1;
   endfunction

   task automatic set_in(input bit v, input int rd, input bit wr, input int rs1, input bit u1,
                         input int rs2, input bit u2, input bit wbv, input int wbrd, input bit fl);
      ISSUE_VALID    = v;
      ISSUE_RD       = 5'(rd);
      ISSUE_WRITE_RD = wr;
      ISSUE_RS1      = 5'(rs1);
      ISSUE_USE_RS1  = u1;
      ISSUE_RS2      = 5'(rs2);
      ISSUE_USE_RS2  = u2;
      WB_VALID       = wbv;
      WB_RD          = 5'(wbrd);
      FLUSH          = fl;
   endtask

   // Called at a negedge with inputs applied; checks comb outputs, steps the model, checks state
   task automatic cycle();
      bit er, acc, tw, tb, fl;
      int rd, wbrd;
      logic [31:0] mask;
      #1;
      er = model_ready();
      chk("issue_ready", 32'(ISSUE_READY), 32'(er));
      chk("stall", 32'(STALL), 32'(ISSUE_VALID && !er));
      acc  = ISSUE_VALID && er;
      tw   = ISSUE_WRITE_RD && ISSUE_RD != 5'd0;
      tb   = WB_VALID && WB_RD != 5'd0;
      fl   = FLUSH;
      rd   = int'(ISSUE_RD);
      wbrd = int'(WB_RD);
      @(posedge CLK);
      if (fl) begin
         for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      end else begin
         int old_wb = m_cnt[wbrd];
         if (acc && tw) m_cnt[rd]++;
         if (tb) begin
            if (old_wb == 0) m_err = 1'b1;
            else m_cnt[wbrd]--;
         end
      end
      #1;
      mask = '0;
      for (int i = 0; i < 32; i++) mask[i] = (m_cnt[i] != 0);
      chk("busy_mask", BUSY_MASK, mask);
      chk("inflight", 32'(INFLIGHT_COUNT), 32'(model_sum()));
      chk("err_underflow", 32'(ERR_UNDERFLOW), 32'(m_err));
      @(negedge CLK);
   endtask

   task automatic idle();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
   endtask

   // Async reset asserted off the clock edge; effects must be visible before any edge
   task automatic do_reset();
      set_in(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      #2;
      RST = 1'b1;
      #1;
      chk("rst_busy_mask", BUSY_MASK, 32'h0);
      chk("rst_inflight", 32'(INFLIGHT_COUNT), 32'h0);
      chk("rst_ready", 32'(ISSUE_READY), 32'h0);
      chk("rst_stall", 32'(STALL), 32'h1);
      chk("rst_err", 32'(ERR_UNDERFLOW), 32'h0);
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_err = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      RST = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_err = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);

      // RAW stall then bypass release
      do_reset();
      set_in(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); cycle();
      set_in(1, 0, 0, 5, 1, 0, 0, 0, 0, 0); #1 chk("raw_stall", 32'(STALL), 32'h1); cycle();
      idle();
      set_in(1, 0, 0, 5, 1, 0, 0, 1, 5, 0); #1 chk("raw_bypass_ready", 32'(ISSUE_READY), 32'h1); cycle();
      chk("raw_busy5_clear", 32'(BUSY_MASK[5]), 32'h0);

      // WAW accumulation and saturation
      do_reset();
      for (int k = 0; k < 3; k++) begin
         set_in(1, 7, 1, 0, 0, 0, 0, 0, 0, 0); cycle();
      end
      chk("waw_inflight3", 32'(INFLIGHT_COUNT), 32'h3);
      set_in(1, 7, 1, 0, 0, 0, 0, 0, 0, 0); #1 chk("sat_stall", 32'(STALL), 32'h1); cycle();
      set_in(1, 7, 1, 0, 0, 0, 0, 1, 7, 0); #1 chk("sat_wb_ready", 32'(ISSUE_READY), 32'h1); cycle();
      chk("sat_count_held", 32'(INFLIGHT_COUNT), 32'h3);

      // In-flight capacity
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         set_in(1, k, 1, 0, 0, 0, 0, 0, 0, 0); cycle();
      end
      chk("cap_full", 32'(INFLIGHT_COUNT), 32'h8);
      set_in(1, 9, 1, 0, 0, 0, 0, 0, 0, 0); #1 chk("cap_stall", 32'(STALL), 32'h1); cycle();
      set_in(1, 9, 1, 0, 0, 0, 0, 1, 1, 0); #1 chk("cap_wb_ready", 32'(ISSUE_READY), 32'h1); cycle();
      chk("cap_count_held", 32'(INFLIGHT_COUNT), 32'h8);
      chk("cap_swap_mask", BUSY_MASK & 32'h0000_0202, 32'h0000_0200);

      // x0 untracked, underflow sticky
      do_reset();
      for (int k = 0; k < 4; k++) begin
         set_in(1, 0, 1, 0, 1, 0, 1, 0, 0, 0); #1 chk("x0_no_stall", 32'(STALL), 32'h0); cycle();
      end
      chk("x0_inflight", 32'(INFLIGHT_COUNT), 32'h0);
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle();
      chk("x0_wb_no_err", 32'(ERR_UNDERFLOW), 32'h0);
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 9, 0); cycle();
      chk("underflow_set", 32'(ERR_UNDERFLOW), 32'h1);
      chk("underflow_mask", BUSY_MASK, 32'h0);

      // FLUSH with pending counts and a concurrent issue
      do_reset();
      set_in(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); cycle();
      set_in(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); cycle();
      set_in(1, 4, 1, 0, 0, 0, 0, 0, 0, 0); cycle();
      chk("pre_flush_inflight", 32'(INFLIGHT_COUNT), 32'h3);
      set_in(1, 6, 1, 0, 0, 0, 0, 0, 0, 1); #1 chk("flush_ready", 32'(ISSUE_READY), 32'h0); cycle();
      chk("flush_mask", BUSY_MASK, 32'h0);
      chk("flush_inflight", 32'(INFLIGHT_COUNT), 32'h0);

      // Random traffic over a small register window so hazards are frequent
      do_reset();
      for (int n = 0; n < 400; n++) begin
         if (n == 250) begin
            chk("pre_midrun_rst_busy", 32'(BUSY_MASK != 32'h0 || INFLIGHT_COUNT == 4'd0), 32'h1);
            do_reset();
         end
         set_in($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 39) == 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
